// File: rtl/sram_linebuf_ctrl.sv
// Circular line-buffer controller: generates SRAM write/read addresses for a LINE_NUM-line
// window, starts streaming after START_LINES lines, obeys backpressure, flushes and flags frame end.
module sram_linebuf_ctrl #(
    parameter int DATA_WIDTH   = 16,
    parameter int IMAGE_WIDTH  = 4032,
    parameter int IMAGE_HEIGHT = 3024,
    parameter int LINE_NUM     = 8,
    parameter int START_LINES  = 5,
    parameter int ADDR_WIDTH   = $clog2(LINE_NUM * IMAGE_WIDTH),
    parameter int RD_LATENCY   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  in_ready_o,
    output logic                  wren_to_sram_o,
    output logic [ADDR_WIDTH-1:0] wraddr_to_sram_o,
    output logic [DATA_WIDTH-1:0] wrdata_to_sram_o,
    output logic                  rden_from_sram_o,
    output logic [ADDR_WIDTH-1:0] rdaddr_from_sram_o,
    input  logic                  ready_i,
    output logic                  wren_to_process_o,
    output logic                  frame_done_o,
    output logic [2:0]            state_o
);

    localparam int DEPTH  = LINE_NUM * IMAGE_WIDTH;
    localparam int TOTAL  = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam int DRN_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    localparam logic [CNT_W-1:0]      C_TOTAL    = CNT_W'(TOTAL);
    localparam logic [FILL_W-1:0]     C_DEPTH    = FILL_W'(DEPTH);
    localparam logic [FILL_W-1:0]     C_START    = FILL_W'(START_LINES * IMAGE_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] C_PTR_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [DRN_W-1:0]      C_DRN_LAST = DRN_W'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        STORE        = 3'd1,
        STORE_PUSH   = 3'd2,
        WAIT_FOR_CAL = 3'd3,
        FLUSH        = 3'd4,
        DRAIN        = 3'd5
    } state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_in_cnt;
    logic [CNT_W-1:0]        r_out_cnt;
    logic [FILL_W-1:0]       r_fill;
    logic [ADDR_WIDTH-1:0]   r_wr_ptr;
    logic [ADDR_WIDTH-1:0]   r_rd_ptr;
    logic [DRN_W-1:0]        r_drain_cnt;
    logic                    r_wren;
    logic [ADDR_WIDTH-1:0]   r_wraddr;
    logic [DATA_WIDTH-1:0]   r_wrdata;
    logic                    r_rden;
    logic [ADDR_WIDTH-1:0]   r_rdaddr;
    logic [RD_LATENCY-1:0]   r_vld_pipe;
    logic                    r_done;

    logic                    w_in_state;
    logic                    w_accept;
    logic                    w_rd_go;
    logic                    w_abort;
    logic [FILL_W-1:0]       w_fill_nxt;
    logic [ADDR_WIDTH-1:0]   w_wr_ptr_nxt;
    logic [ADDR_WIDTH-1:0]   w_rd_ptr_nxt;
    logic [RD_LATENCY-1:0]   w_vld_nxt;

    // Handshakes: a pixel moves upstream only when valid_i && in_ready_o in the same cycle;
    // a read is issued when ready_i is high in a reading state, and the process stage must
    // still absorb up to RD_LATENCY pixels already in flight after ready_i drops.
    assign w_in_state = (r_state == STORE) || (r_state == STORE_PUSH) || (r_state == WAIT_FOR_CAL);
    assign in_ready_o = en_i && w_in_state && (r_fill < C_DEPTH) && (r_in_cnt < C_TOTAL);
    assign w_accept   = valid_i && in_ready_o;
    assign w_rd_go    = ready_i && (r_fill != '0) && ((r_state == STORE_PUSH) || (r_state == FLUSH));
    assign w_abort    = (r_state != IDLE) && !en_i;

    assign w_wr_ptr_nxt = (r_wr_ptr == C_PTR_LAST) ? '0 : r_wr_ptr + ADDR_WIDTH'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == C_PTR_LAST) ? '0 : r_rd_ptr + ADDR_WIDTH'(1);
    assign w_vld_nxt    = RD_LATENCY'({r_vld_pipe, r_rden});

    always_comb begin
        w_fill_nxt = r_fill;
        if (w_accept && !w_rd_go) begin
            w_fill_nxt = r_fill + FILL_W'(1);
        end else if (!w_accept && w_rd_go) begin
            w_fill_nxt = r_fill - FILL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_fill      <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_drain_cnt <= '0;
            r_wren      <= 1'b0;
            r_wraddr    <= '0;
            r_wrdata    <= '0;
            r_rden      <= 1'b0;
            r_rdaddr    <= '0;
            r_vld_pipe  <= '0;
            r_done      <= 1'b0;
        end else if (w_abort) begin
            // Abort drops the frame outright, including reads still in the delay line.
            r_state     <= IDLE;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_fill      <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_drain_cnt <= '0;
            r_wren      <= 1'b0;
            r_rden      <= 1'b0;
            r_vld_pipe  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_wren     <= w_accept;
            r_rden     <= w_rd_go;
            r_vld_pipe <= w_vld_nxt;
            r_done     <= 1'b0;
            r_fill     <= w_fill_nxt;
            if (w_accept) begin
                r_wraddr <= r_wr_ptr;
                r_wrdata <= data_i;
                r_wr_ptr <= w_wr_ptr_nxt;
                r_in_cnt <= r_in_cnt + CNT_W'(1);
            end
            if (w_rd_go) begin
                r_rdaddr  <= r_rd_ptr;
                r_rd_ptr  <= w_rd_ptr_nxt;
                r_out_cnt <= r_out_cnt + CNT_W'(1);
            end
            case (r_state)
                IDLE: begin
                    r_in_cnt    <= '0;
                    r_out_cnt   <= '0;
                    r_fill      <= '0;
                    r_wr_ptr    <= '0;
                    r_rd_ptr    <= '0;
                    r_drain_cnt <= '0;
                    if (en_i) r_state <= STORE;
                end
                STORE: begin
                    // A frame shorter than the start window goes straight to flushing.
                    if (r_in_cnt == C_TOTAL) r_state <= FLUSH;
                    else if (r_fill >= C_START) r_state <= STORE_PUSH;
                end
                STORE_PUSH: begin
                    if (r_in_cnt == C_TOTAL) r_state <= FLUSH;
                    else if (!ready_i) r_state <= WAIT_FOR_CAL;
                end
                WAIT_FOR_CAL: begin
                    if (r_in_cnt == C_TOTAL) r_state <= FLUSH;
                    else if (ready_i) r_state <= STORE_PUSH;
                end
                FLUSH: begin
                    if (r_out_cnt == C_TOTAL) begin
                        r_state     <= DRAIN;
                        r_drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (r_drain_cnt == C_DRN_LAST) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + DRN_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wren_to_sram_o     = r_wren;
    assign wraddr_to_sram_o   = r_wraddr;
    assign wrdata_to_sram_o   = r_wrdata;
    assign rden_from_sram_o   = r_rden;
    assign rdaddr_from_sram_o = r_rdaddr;
    assign wren_to_process_o  = r_vld_pipe[RD_LATENCY-1];
    assign frame_done_o       = r_done;
    assign state_o            = r_state;

endmodule

// File: tb/tb_sram_linebuf_ctrl.sv
// Bench for sram_linebuf_ctrl on an 8x6 frame with a 4-line (32-pixel) buffer:
// a vector table for reset/first writes, then hand-written multi-cycle sequences.
module tb_sram_linebuf_ctrl;

    localparam int DW = 16;
    localparam int AW = 5;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_STORE = 3'd1;
    localparam logic [2:0] S_PUSH  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en_i = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          in_ready_o;
    logic          wren_to_sram_o;
    logic [AW-1:0] wraddr_to_sram_o;
    logic [DW-1:0] wrdata_to_sram_o;
    logic          rden_from_sram_o;
    logic [AW-1:0] rdaddr_from_sram_o;
    logic          wren_to_process_o;
    logic          frame_done_o;
    logic [2:0]    state_o;

    sram_linebuf_ctrl #(
        .DATA_WIDTH(DW), .IMAGE_WIDTH(8), .IMAGE_HEIGHT(6), .LINE_NUM(4),
        .START_LINES(2), .ADDR_WIDTH(AW), .RD_LATENCY(1)
    ) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .valid_i(valid_i), .data_i(data_i),
        .in_ready_o(in_ready_o), .wren_to_sram_o(wren_to_sram_o),
        .wraddr_to_sram_o(wraddr_to_sram_o), .wrdata_to_sram_o(wrdata_to_sram_o),
        .rden_from_sram_o(rden_from_sram_o), .rdaddr_from_sram_o(rdaddr_from_sram_o),
        .ready_i(ready_i), .wren_to_process_o(wren_to_process_o),
        .frame_done_o(frame_done_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst, en, valid, ready;
        logic [DW-1:0] data;
        logic [2:0]    st;
        logic          ir, wren;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } vec_t;

    vec_t vec[11];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_acc, n_wren, n_rden, n_proc, n_done, last_proc_cyc, done_cyc;
    logic [2:0] done_state;
    logic [AW-1:0] exp_wr_q[$];
    logic [AW-1:0] exp_rd_q[$];
    logic [DW-1:0] exp_wd_q[$];

    function automatic vec_t mk(logic r, logic e, logic v, logic rd, logic [DW-1:0] d,
                                logic [2:0] st, logic ir, logic we, logic [AW-1:0] wa,
                                logic [DW-1:0] wd);
        vec_t t;
        t.rst = r; t.en = e; t.valid = v; t.ready = rd; t.data = d;
        t.st = st; t.ir = ir; t.wren = we; t.wa = wa; t.wd = wd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_acc = 0; n_wren = 0; n_rden = 0; n_proc = 0; n_done = 0;
        last_proc_cyc = -1; done_cyc = -1; done_state = 3'd7;
        exp_wr_q.delete(); exp_rd_q.delete(); exp_wd_q.delete();
    endtask

    // One cycle: drive at the falling edge, sample 1 ns later, score SRAM traffic.
    task automatic tick(input logic e, input logic v, input logic r);
        @(negedge clk);
        en_i = e; valid_i = v; ready_i = r; data_i = 16'hA000 + 16'(n_acc);
        #1;
        cyc++;
        if (v && in_ready_o) n_acc++;
        if (wren_to_sram_o) begin
            n_wren++;
            if (exp_wr_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL wr_unexpected: got write to %0h expected none", wraddr_to_sram_o);
            end else begin
                chk("wraddr", 32'(wraddr_to_sram_o), 32'(exp_wr_q.pop_front()));
            end
            if (exp_wd_q.size() > 0) chk("wrdata", 32'(wrdata_to_sram_o), 32'(exp_wd_q.pop_front()));
        end
        if (rden_from_sram_o) begin
            n_rden++;
            if (exp_rd_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL rd_unexpected: got read of %0h expected none", rdaddr_from_sram_o);
            end else begin
                chk("rdaddr", 32'(rdaddr_from_sram_o), 32'(exp_rd_q.pop_front()));
            end
        end
        if (wren_to_process_o) begin n_proc++; last_proc_cyc = cyc; end
        if (frame_done_o) begin n_done++; done_cyc = cyc; done_state = state_o; end
    endtask

    initial begin
        int base, first_push, first_rd, first_proc, acc_before;
        bit saw_last, ir_checked;

        // Reset, first writes, asynchronous reset mid-stream, restart from address 0.
        vec[0]  = mk(1, 0, 0, 0, 16'h0000, S_IDLE,  0, 0, 0, 0);
        vec[1]  = mk(0, 1, 1, 0, 16'h0100, S_IDLE,  0, 0, 0, 0);
        vec[2]  = mk(0, 1, 1, 0, 16'h0100, S_STORE, 1, 0, 0, 0);
        vec[3]  = mk(0, 1, 1, 0, 16'h0101, S_STORE, 1, 1, 0, 16'h0100);
        vec[4]  = mk(0, 1, 0, 0, 16'h0000, S_STORE, 1, 1, 1, 16'h0101);
        vec[5]  = mk(0, 1, 1, 0, 16'h0102, S_STORE, 1, 0, 0, 0);
        vec[6]  = mk(1, 1, 1, 0, 16'h0103, S_IDLE,  0, 0, 0, 0);
        vec[7]  = mk(0, 1, 1, 0, 16'h0200, S_IDLE,  0, 0, 0, 0);
        vec[8]  = mk(0, 1, 1, 0, 16'h0200, S_STORE, 1, 0, 0, 0);
        vec[9]  = mk(0, 1, 0, 0, 16'h0000, S_STORE, 1, 1, 0, 16'h0200);
        vec[10] = mk(0, 1, 0, 0, 16'h0000, S_STORE, 1, 0, 0, 0);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            rst = vec[i].rst; en_i = vec[i].en; valid_i = vec[i].valid;
            ready_i = vec[i].ready; data_i = vec[i].data;
            #1;
            chk($sformatf("v%0d_state", i), 32'(state_o), 32'(vec[i].st));
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready_o), 32'(vec[i].ir));
            chk($sformatf("v%0d_wren", i), 32'(wren_to_sram_o), 32'(vec[i].wren));
            if (vec[i].wren) begin
                chk($sformatf("v%0d_wraddr", i), 32'(wraddr_to_sram_o), 32'(vec[i].wa));
                chk($sformatf("v%0d_wrdata", i), 32'(wrdata_to_sram_o), 32'(vec[i].wd));
            end
            chk($sformatf("v%0d_rden", i), 32'(rden_from_sram_o), 32'(0));
            chk($sformatf("v%0d_proc", i), 32'(wren_to_process_o), 32'(0));
            chk($sformatf("v%0d_done", i), 32'(frame_done_o), 32'(0));
        end

        // Full frame with ready_i held high: start threshold, flush and frame_done timing.
        do_reset();
        for (int k = 0; k < 48; k++) begin
            exp_wr_q.push_back(AW'(k % 32));
            exp_rd_q.push_back(AW'(k % 32));
            exp_wd_q.push_back(16'hA000 + 16'(k));
        end
        base = cyc + 1;
        first_push = -1; first_rd = -1; first_proc = -1;
        saw_last = 0; ir_checked = 0;
        for (int i = 0; i < 200 && n_done == 0; i++) begin
            tick(1, 1, 1);
            if (first_push < 0 && state_o == S_PUSH) begin
                first_push = cyc;
                chk("writes_before_push", 32'(n_wren - int'(wren_to_sram_o)), 32'(16));
            end
            if (first_rd < 0 && rden_from_sram_o) first_rd = cyc;
            if (first_proc < 0 && wren_to_process_o) first_proc = cyc;
            if (saw_last && !ir_checked) begin
                chk("in_ready_after_48", 32'(in_ready_o), 32'(0));
                ir_checked = 1;
            end
            if (n_acc == 48) saw_last = 1;
        end
        for (int i = 0; i < 3; i++) tick(1, 0, 1);
        chk("push_cycle", 32'(first_push - base), 32'(18));
        chk("first_rd_lag", 32'(first_rd - first_push), 32'(1));
        chk("first_proc_lag", 32'(first_proc - first_rd), 32'(1));
        chk("ir_checked", 32'(ir_checked), 32'(1));
        chk("flush_accepts", 32'(n_acc), 32'(48));
        chk("flush_writes", 32'(n_wren), 32'(48));
        chk("flush_reads", 32'(n_rden), 32'(48));
        chk("flush_proc", 32'(n_proc), 32'(48));
        chk("flush_done_cnt", 32'(n_done), 32'(1));
        chk("done_after_proc", 32'(done_cyc - last_proc_cyc), 32'(1));
        chk("done_state", 32'(done_state), 32'(S_IDLE));
        chk("flush_rdq_left", 32'(exp_rd_q.size()), 32'(0));
        chk("flush_wrq_left", 32'(exp_wr_q.size()), 32'(0));

        // Backpressure from the start: fill to 32, one read frees one slot, write wraps.
        do_reset();
        for (int k = 0; k < 32; k++) exp_wr_q.push_back(AW'(k));
        exp_wr_q.push_back(AW'(0));
        exp_rd_q.push_back(AW'(0));
        for (int i = 0; i < 40; i++) tick(1, 1, 0);
        chk("bp_accepts", 32'(n_acc), 32'(32));
        chk("bp_full_ready", 32'(in_ready_o), 32'(0));
        chk("bp_state", 32'(state_o), 32'(S_WAIT));
        tick(1, 1, 1);
        chk("bp_full_wait", 32'(in_ready_o), 32'(0));
        chk("bp_no_read_in_wait", 32'(rden_from_sram_o), 32'(0));
        tick(1, 1, 1);
        chk("bp_full_while_read", 32'(in_ready_o), 32'(0));
        chk("bp_push_state", 32'(state_o), 32'(S_PUSH));
        tick(1, 1, 0);
        chk("bp_read_issued", 32'(rden_from_sram_o), 32'(1));
        chk("bp_resume", 32'(in_ready_o), 32'(1));
        tick(1, 0, 0);
        chk("bp_wrap_write", 32'(wren_to_sram_o), 32'(1));
        chk("bp_single_read", 32'(rden_from_sram_o), 32'(0));
        tick(1, 1, 0);
        chk("bp_full_again", 32'(in_ready_o), 32'(0));
        chk("bp_reads", 32'(n_rden), 32'(1));
        chk("bp_wrq_left", 32'(exp_wr_q.size()), 32'(0));

        // Simultaneous read and write at fill 20: addresses advance together, fill holds.
        do_reset();
        for (int k = 0; k < 37; k++) exp_wr_q.push_back(AW'(k % 32));
        for (int k = 0; k < 5; k++) exp_rd_q.push_back(AW'(k));
        for (int i = 0; i < 40 && n_acc < 20; i++) tick(1, 1, 0);
        chk("rw_reach_20", 32'(n_acc), 32'(20));
        tick(1, 0, 1);
        chk("rw_wait_state", 32'(state_o), 32'(S_WAIT));
        for (int i = 0; i < 6; i++) begin
            if (i < 5) tick(1, 1, 1);
            else tick(1, 0, 0);
            if (i < 5) chk("rw_in_ready", 32'(in_ready_o), 32'(1));
            if (i > 0) begin
                chk("rw_lockstep", 32'({wren_to_sram_o, rden_from_sram_o}), 32'(2'b11));
                chk("rw_addr_gap", 32'(AW'(wraddr_to_sram_o - rdaddr_from_sram_o)), 32'(20));
            end
        end
        acc_before = n_acc;
        for (int i = 0; i < 20; i++) tick(1, 1, 0);
        chk("rw_room_left", 32'(n_acc - acc_before), 32'(12));
        chk("rw_full", 32'(in_ready_o), 32'(0));
        chk("rw_wrq_left", 32'(exp_wr_q.size()), 32'(0));
        chk("rw_rdq_left", 32'(exp_rd_q.size()), 32'(0));

        // Abort at in_cnt 20: back to IDLE without frame_done, next frame starts at address 0.
        do_reset();
        for (int k = 0; k < 20; k++) exp_wr_q.push_back(AW'(k));
        exp_wr_q.push_back(AW'(0));
        for (int i = 0; i < 40 && n_acc < 20; i++) tick(1, 1, 0);
        chk("ab_reach_20", 32'(n_acc), 32'(20));
        tick(0, 1, 0);
        chk("ab_en_low_blocks", 32'(in_ready_o), 32'(0));
        tick(0, 0, 0);
        chk("ab_idle", 32'(state_o), 32'(S_IDLE));
        chk("ab_no_write", 32'(wren_to_sram_o), 32'(0));
        for (int i = 0; i < 3; i++) tick(0, 0, 0);
        chk("ab_no_done", 32'(n_done), 32'(0));
        tick(1, 1, 0);
        chk("ab_restart_idle_ready", 32'(in_ready_o), 32'(0));
        tick(1, 1, 0);
        chk("ab_restart_accept", 32'(in_ready_o), 32'(1));
        tick(1, 0, 0);
        chk("ab_restart_write", 32'(wren_to_sram_o), 32'(1));
        chk("ab_wrq_left", 32'(exp_wr_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_linebuf_ctrl.md
Name: sram_linebuf_ctrl

Overview:
Parametrised circular line-buffer controller for the RAWDNS NLM path. It generates write and read addresses for one simple dual-port SRAM that holds LINE_NUM image lines. Once START_LINES lines are buffered, it streams pixels to the process stage under ready backpressure, stalls upstream when the buffer is full, flushes the tail of the frame, and flags frame completion.

Parameters:
DATA_WIDTH, 16, pixel width
IMAGE_WIDTH, 4032, pixels per line (W)
IMAGE_HEIGHT, 3024, lines per frame (H)
LINE_NUM, 8, lines held in SRAM; DEPTH = LINE_NUM*W; must exceed START_LINES
START_LINES, 5, lines buffered before reading starts (2*WIN_RADIUS+1)
ADDR_WIDTH, clog2(LINE_NUM*IMAGE_WIDTH), SRAM address width
RD_LATENCY, 1, SRAM read latency in cycles (1..3)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
en_i  input  1  module enable; low aborts the frame
valid_i  input  1  upstream pixel valid
data_i  input  DATA_WIDTH  upstream pixel
in_ready_o  output  1  controller accepts pixel (combinational)
wren_to_sram_o  output  1  SRAM write enable
wraddr_to_sram_o  output  ADDR_WIDTH  SRAM write address
wrdata_to_sram_o  output  DATA_WIDTH  SRAM write data
rden_from_sram_o  output  1  SRAM read enable
rdaddr_from_sram_o  output  ADDR_WIDTH  SRAM read address
ready_i  input  1  process stage can take a pixel
wren_to_process_o  output  1  SRAM read data valid to process
frame_done_o  output  1  one-cycle pulse at end of frame

Behaviour:
- Clocking and reset: single clk. rst is asynchronous and active-high. While rst is high, all outputs, counters and pointers are 0 and the state is IDLE.
- Counters:
  - in_cnt and out_cnt are clog2(W*H+1) bits wide.
  - fill is clog2(DEPTH+1) bits wide and holds the number of accepted pixels not yet read.
  - wr_ptr and rd_ptr are 0..DEPTH-1 and wrap from DEPTH-1 to 0.
- Accept: accept = valid_i && in_ready_o.
  - in_ready_o = en_i && state in {STORE, STORE_PUSH, WAIT_FOR_CAL} && fill < DEPTH && in_cnt < W*H.
- Write timing: in the cycle after an accept, wren_to_sram_o=1, wraddr_to_sram_o=wr_ptr (old value) and wrdata_to_sram_o=data_i. wr_ptr then increments.
- Read issue: rd_go = ready_i && fill > 0 && (state==STORE_PUSH || state==FLUSH).
  - In the cycle after rd_go: rden_from_sram_o=1 and rdaddr_from_sram_o=rd_ptr (old value). rd_ptr increments and out_cnt increments.
  - fill uses only registered values, so a read never targets the pixel accepted in the same cycle.
- Output valid: wren_to_process_o equals rden_from_sram_o delayed by RD_LATENCY cycles. The process stage must absorb up to RD_LATENCY in-flight pixels after it drops ready_i.
- Fill update: fill += accept − rd_go. When both happen in one cycle, fill is unchanged.
- FSM:
  - IDLE: counters cleared. en_i=1 -> STORE.
  - STORE: writes only. fill >= START_LINES*W -> STORE_PUSH.
  - STORE_PUSH: reads and writes. ready_i=0 -> WAIT_FOR_CAL. in_cnt==W*H -> FLUSH (takes priority).
  - WAIT_FOR_CAL: writes continue, no reads. ready_i=1 -> STORE_PUSH. in_cnt==W*H -> FLUSH.
  - FLUSH: no accepts; reads gated by ready_i. out_cnt==W*H -> DRAIN.
  - DRAIN: wait RD_LATENCY cycles for the last valid, then pulse frame_done_o for one cycle -> IDLE.
- Boundaries:
  - Full (fill==DEPTH): in_ready_o=0, even in a cycle that issues a read. Accepts resume the next cycle.
  - If the frame has fewer than START_LINES lines (H < START_LINES), STORE -> FLUSH when in_cnt==W*H.
  - en_i=0 in any non-IDLE state: synchronous abort to IDLE. Counters and pointers clear, delay-line valids clear, and no frame_done_o pulse is generated.
  - rst mid-frame: immediate clear, same as reset.

Test Plan (W=8, H=6, LINE_NUM=4, START_LINES=2, RD_LATENCY=1, DEPTH=32):
1. Reset: assert rst mid-stream -> all outputs 0 asynchronously. Release, raise en_i, hold valid_i=1 -> first wren_to_sram_o one cycle after the first accept with wraddr=0.
2. Start threshold: valid_i=1 continuous, ready_i=1 -> state reaches STORE_PUSH when fill=16. The first rden_from_sram_o has rdaddr=0, and wren_to_process_o follows one cycle later.
3. Backpressure: ready_i=0 from start -> exactly 32 accepts, then in_ready_o=0. Pulse ready_i for one cycle -> one read (rdaddr=0), one more accept, wraddr_to_sram_o wraps to 0.
4. Simultaneous read/write: at fill=20, valid_i=1 and ready_i=1 for 5 cycles -> fill stays 20, and addresses advance in lockstep.
5. Flush: 48 pixels in, ready_i=1 -> in_ready_o=0 after the 48th accept. Exactly 48 reads follow with rdaddr sequence 0..31 then 0..15. frame_done_o pulses once, one cycle after the last wren_to_process_o.
6. Abort: drop en_i at in_cnt=20 -> IDLE next cycle, no frame_done_o. A new frame then restarts with wraddr=0.
